// File: rtl/arp_resolve_client.sv
// arp_resolve_client: resolves one IPv4 address at a time to a MAC through the
// network layer's ARP cache. On a miss it triggers an ARP request, backs off and
// re-queries until it gets a hit or runs out of retries.
module arp_resolve_client #(
    parameter int unsigned RETRY_MAX   = 3,
    parameter int unsigned WAIT_CYCLES = 200000
) (
    input  logic        logic_clk,
    input  logic        logic_rst,
    input  logic [31:0] req_ip_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    output logic [47:0] rsp_mac_out,
    output logic        rsp_err_out,
    output logic        rsp_valid_out,
    input  logic        rsp_ready_in,
    output logic [31:0] arp_query_ip_out,
    output logic        arp_query_valid_out,
    input  logic        arp_query_ready_in,
    input  logic [47:0] arp_response_mac_in,
    input  logic        arp_response_valid_in,
    input  logic        arp_response_err_in,
    output logic        arp_response_ready_out,
    output logic [31:0] trig_arp_ip_out,
    output logic        trig_arp_qvalid_out,
    input  logic        trig_arp_qready_in
);

    localparam int unsigned RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam int unsigned TIMER_W = $clog2(WAIT_CYCLES);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_MAX);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUERY,
        S_WAIT_RSP,
        S_TRIGGER,
        S_BACKOFF,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        ip_q;
    logic [47:0]        mac_q;
    logic               err_q;
    logic [RETRY_W-1:0] retry_cnt;
    logic [TIMER_W-1:0] timer;

    logic timer_done;
    logic retries_spent;
    logic rsp_hit;
    logic rsp_miss;

    assign timer_done    = (timer == TIMER_LAST);
    assign retries_spent = (retry_cnt == RETRY_LAST);
    // A response in the same cycle as watchdog expiry takes priority.
    assign rsp_hit       = arp_response_valid_in && !arp_response_err_in;
    assign rsp_miss      = arp_response_valid_in ? arp_response_err_in : timer_done;

    assign rsp_mac_out      = mac_q;
    assign rsp_err_out      = err_q;
    assign arp_query_ip_out = ip_q;
    assign trig_arp_ip_out  = ip_q;

    // State register.
    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid_in) state_nxt = S_QUERY;
            end
            S_QUERY: begin
                if (arp_query_ready_in) state_nxt = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (rsp_hit) begin
                    state_nxt = S_DONE;
                end else if (rsp_miss) begin
                    state_nxt = retries_spent ? S_DONE : S_TRIGGER;
                end
            end
            S_TRIGGER: begin
                if (trig_arp_qready_in) state_nxt = S_BACKOFF;
            end
            S_BACKOFF: begin
                if (timer_done) state_nxt = S_QUERY;
            end
            S_DONE: begin
                if (rsp_ready_in) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake flags registered from the next state; datapath registers and counters.
    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            req_ready_out          <= 1'b1;
            arp_query_valid_out    <= 1'b0;
            arp_response_ready_out <= 1'b0;
            trig_arp_qvalid_out    <= 1'b0;
            rsp_valid_out          <= 1'b0;
            ip_q                   <= '0;
            mac_q                  <= '0;
            err_q                  <= 1'b0;
            retry_cnt              <= '0;
            timer                  <= '0;
        end else begin
            req_ready_out          <= (state_nxt == S_IDLE);
            arp_query_valid_out    <= (state_nxt == S_QUERY);
            arp_response_ready_out <= (state_nxt == S_WAIT_RSP);
            trig_arp_qvalid_out    <= (state_nxt == S_TRIGGER);
            rsp_valid_out          <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (req_valid_in) begin
                        ip_q      <= req_ip_in;
                        retry_cnt <= '0;
                    end
                end
                S_QUERY: begin
                    if (arp_query_ready_in) timer <= '0;
                end
                S_WAIT_RSP: begin
                    if (!timer_done) timer <= timer + TIMER_W'(1);
                    if (rsp_hit) begin
                        mac_q <= arp_response_mac_in;
                        err_q <= 1'b0;
                    end else if (rsp_miss && retries_spent) begin
                        mac_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                S_TRIGGER: begin
                    if (trig_arp_qready_in) begin
                        if (!retries_spent) retry_cnt <= retry_cnt + RETRY_W'(1);
                        timer <= '0;
                    end
                end
                S_BACKOFF: begin
                    if (!timer_done) timer <= timer + TIMER_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arp_resolve_client.sv
// tb_arp_resolve_client: drives requests, plays the ARP cache/trigger side from a
// scripted per-query outcome list, and checks results and timing against a
// protocol-level model of the resolution sequence.
module tb_arp_resolve_client;

    localparam int RM = 3;
    localparam int WC = 16;
    localparam int OC_HIT  = 0;
    localparam int OC_MISS = 1;
    localparam int OC_TMO  = 2;
    localparam int PH_Q = 0;
    localparam int PH_R = 1;
    localparam int PH_T = 2;
    localparam int PH_D = 3;
    localparam logic [117:0] RST_VAL = {1'b1, 117'b0};

    logic        logic_clk = 1'b0;
    logic        logic_rst = 1'b1;
    logic [31:0] req_ip_in = '0;
    logic        req_valid_in = 1'b0;
    logic        req_ready_out;
    logic [47:0] rsp_mac_out;
    logic        rsp_err_out;
    logic        rsp_valid_out;
    logic        rsp_ready_in = 1'b0;
    logic [31:0] arp_query_ip_out;
    logic        arp_query_valid_out;
    logic        arp_query_ready_in = 1'b0;
    logic [47:0] arp_response_mac_in = '0;
    logic        arp_response_valid_in = 1'b0;
    logic        arp_response_err_in = 1'b0;
    logic        arp_response_ready_out;
    logic [31:0] trig_arp_ip_out;
    logic        trig_arp_qvalid_out;
    logic        trig_arp_qready_in = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // Scripted environment for the next request: per-query outcome, MAC, response delay.
    int          oc   [RM+1];
    logic [47:0] omac [RM+1];
    int          odly [RM+1];
    int          qdly, tdly, rdly;

    arp_resolve_client #(.RETRY_MAX(RM), .WAIT_CYCLES(WC)) dut (
        .logic_clk              (logic_clk),
        .logic_rst              (logic_rst),
        .req_ip_in              (req_ip_in),
        .req_valid_in           (req_valid_in),
        .req_ready_out          (req_ready_out),
        .rsp_mac_out            (rsp_mac_out),
        .rsp_err_out            (rsp_err_out),
        .rsp_valid_out          (rsp_valid_out),
        .rsp_ready_in           (rsp_ready_in),
        .arp_query_ip_out       (arp_query_ip_out),
        .arp_query_valid_out    (arp_query_valid_out),
        .arp_query_ready_in     (arp_query_ready_in),
        .arp_response_mac_in    (arp_response_mac_in),
        .arp_response_valid_in  (arp_response_valid_in),
        .arp_response_err_in    (arp_response_err_in),
        .arp_response_ready_out (arp_response_ready_out),
        .trig_arp_ip_out        (trig_arp_ip_out),
        .trig_arp_qvalid_out    (trig_arp_qvalid_out),
        .trig_arp_qready_in     (trig_arp_qready_in)
    );

    always #5 logic_clk = ~logic_clk;

    function automatic logic [47:0] rand48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    function automatic logic [117:0] all_outs();
        return {req_ready_out, arp_query_valid_out, arp_response_ready_out,
                trig_arp_qvalid_out, rsp_valid_out, rsp_err_out, rsp_mac_out,
                arp_query_ip_out, trig_arp_ip_out};
    endfunction

    task automatic set_case(input int o0, input int o1, input int o2, input int o3);
        oc[0] = o0; oc[1] = o1; oc[2] = o2; oc[3] = o3;
        for (int i = 0; i <= RM; i++) begin
            omac[i] = rand48();
            odly[i] = 0;
        end
        qdly = 0; tdly = 0; rdly = 0;
    endtask

    // One request end to end; optionally pulses reset in the first backoff and abandons it.
    task automatic run_request(input logic [31:0] ip, input bit do_rst, input string tag);
        int exp_q, exp_t, nq, nt, cyc, exp_at, base, waitc, ph, k;
        logic        exp_err;
        logic [47:0] exp_mac;
        logic [2:0]  vv, vexp;
        bit          fin, found, ev;

        // Model: first hit among RM+1 queries wins; otherwise error with MAC 0.
        found = 0; exp_q = RM + 1; exp_err = 1'b1; exp_mac = '0;
        for (int i = 0; i <= RM; i++) begin
            if (!found && oc[i] == OC_HIT) begin
                found = 1; exp_q = i + 1; exp_err = 1'b0; exp_mac = omac[i];
            end
        end
        exp_t = found ? exp_q - 1 : RM;

        vectors++;
        if (req_ready_out !== 1'b1) begin
            miscompares++;
            $display("FAIL %s req_ready before request: got %b want 1", tag, req_ready_out);
        end
        req_ip_in = ip; req_valid_in = 1'b1;
        @(posedge logic_clk); #1;
        req_valid_in = 1'b0; req_ip_in = $urandom;

        nq = 0; nt = 0; cyc = 1; exp_at = 1; ph = PH_Q; waitc = 0; base = 0; fin = 0;
        while (!fin) begin
            arp_query_ready_in = 1'b0; trig_arp_qready_in = 1'b0; rsp_ready_in = 1'b0;
            arp_response_valid_in = 1'b0;
            arp_response_err_in = 1'($urandom);
            arp_response_mac_in = rand48();

            if (do_rst && ph == PH_Q && nt > 0 && cyc == exp_at - 8) begin
                logic_rst = 1'b1;
                @(posedge logic_clk); #1;
                logic_rst = 1'b0;
                vectors++;
                if (all_outs() !== RST_VAL) begin
                    miscompares++;
                    $display("FAIL %s outputs after mid-run reset: got %h want %h", tag, all_outs(), RST_VAL);
                end
                for (int j = 0; j < 3 * WC; j++) begin
                    @(posedge logic_clk); #1;
                    vectors++;
                    if ({req_ready_out, arp_query_valid_out, trig_arp_qvalid_out, rsp_valid_out} !== 4'b1000) begin
                        miscompares++;
                        $display("FAIL %s idle after reset cyc %0d: got %b want 1000", tag, j,
                                 {req_ready_out, arp_query_valid_out, trig_arp_qvalid_out, rsp_valid_out});
                    end
                end
                return;
            end

            if (cyc > 1500) begin
                miscompares++;
                $display("FAIL %s cycle budget: got no completion want done by cycle 1500", tag);
                fin = 1;
            end else begin
                vv = {arp_query_valid_out, trig_arp_qvalid_out, rsp_valid_out};
                case (ph)
                    PH_Q:    vexp = (cyc >= exp_at) ? 3'b100 : 3'b000;
                    PH_T:    vexp = (cyc >= exp_at) ? 3'b010 : 3'b000;
                    PH_D:    vexp = (cyc >= exp_at) ? 3'b001 : 3'b000;
                    default: vexp = 3'b000;
                endcase
                vectors++;
                if (vv !== vexp) begin
                    miscompares++;
                    $display("FAIL %s valids q/t/r cyc %0d: got %b want %b", tag, cyc, vv, vexp);
                end
                vectors++;
                if (req_ready_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s req_ready busy cyc %0d: got %b want 0", tag, cyc, req_ready_out);
                end
                case (ph)
                    PH_Q: if (cyc >= exp_at) begin
                        vectors++;
                        if (arp_query_ip_out !== ip) begin
                            miscompares++;
                            $display("FAIL %s query ip cyc %0d: got %h want %h", tag, cyc, arp_query_ip_out, ip);
                        end
                        if (waitc == qdly) begin
                            arp_query_ready_in = 1'b1; nq++; base = cyc; ph = PH_R; waitc = 0;
                        end else waitc++;
                    end
                    PH_R: begin
                        k = cyc - base;
                        vectors++;
                        if (arp_response_ready_out !== 1'b1) begin
                            miscompares++;
                            $display("FAIL %s response ready cyc %0d: got %b want 1", tag, cyc, arp_response_ready_out);
                        end
                        ev = (oc[nq-1] == OC_TMO) ? (k == WC) : (k == 1 + odly[nq-1]);
                        if (ev) begin
                            if (oc[nq-1] != OC_TMO) begin
                                arp_response_valid_in = 1'b1;
                                arp_response_err_in   = (oc[nq-1] == OC_MISS);
                                arp_response_mac_in   = omac[nq-1];
                            end
                            exp_at = cyc + 1; waitc = 0;
                            if (oc[nq-1] == OC_HIT || nq == RM + 1) ph = PH_D;
                            else ph = PH_T;
                        end
                    end
                    PH_T: if (cyc >= exp_at) begin
                        vectors++;
                        if (trig_arp_ip_out !== ip) begin
                            miscompares++;
                            $display("FAIL %s trigger ip cyc %0d: got %h want %h", tag, cyc, trig_arp_ip_out, ip);
                        end
                        if (waitc == tdly) begin
                            trig_arp_qready_in = 1'b1; nt++; ph = PH_Q; exp_at = cyc + 1 + WC; waitc = 0;
                        end else waitc++;
                    end
                    default: if (cyc >= exp_at) begin
                        vectors++;
                        if (rsp_mac_out !== exp_mac || rsp_err_out !== exp_err) begin
                            miscompares++;
                            $display("FAIL %s rsp payload cyc %0d: got mac %h err %b want mac %h err %b",
                                     tag, cyc, rsp_mac_out, rsp_err_out, exp_mac, exp_err);
                        end
                        if (waitc == rdly) begin
                            rsp_ready_in = 1'b1; fin = 1;
                        end else waitc++;
                    end
                endcase
            end
            @(posedge logic_clk); #1;
            cyc++;
        end
        rsp_ready_in = 1'b0;
        arp_response_valid_in = 1'b0;
        vectors++;
        if ({rsp_valid_out, req_ready_out} !== 2'b01) begin
            miscompares++;
            $display("FAIL %s after consume: got rsp_valid/req_ready %b want 01", tag, {rsp_valid_out, req_ready_out});
        end
        vectors++;
        if (nq !== exp_q || nt !== exp_t) begin
            miscompares++;
            $display("FAIL %s query/trigger counts: got %0d/%0d want %0d/%0d", tag, nq, nt, exp_q, exp_t);
        end
    endtask

    task automatic test_reset();
        logic_rst = 1'b1;
        repeat (3) @(posedge logic_clk);
        #1;
        vectors++;
        if (all_outs() !== RST_VAL) begin
            miscompares++;
            $display("FAIL reset values: got %h want %h", all_outs(), RST_VAL);
        end
        logic_rst = 1'b0;
        @(posedge logic_clk); #1;
        vectors++;
        if (all_outs() !== RST_VAL) begin
            miscompares++;
            $display("FAIL idle after reset release: got %h want %h", all_outs(), RST_VAL);
        end
    endtask

    task automatic test_hit();
        set_case(OC_HIT, OC_HIT, OC_HIT, OC_HIT);
        omac[0] = 48'h0011_2233_4455;
        run_request(32'hC0A8_0001, 1'b0, "hit");
    endtask

    task automatic test_miss_then_hit();
        set_case(OC_MISS, OC_HIT, OC_HIT, OC_HIT);
        odly[0] = 2; odly[1] = 1;
        run_request(32'hC0A8_0001, 1'b0, "miss_then_hit");
    endtask

    task automatic test_exhaustion();
        set_case(OC_MISS, OC_MISS, OC_MISS, OC_MISS);
        run_request(32'h0A00_0002, 1'b0, "exhaustion");
    endtask

    task automatic test_watchdog();
        set_case(OC_TMO, OC_HIT, OC_HIT, OC_HIT);
        run_request(32'h0A00_0003, 1'b0, "watchdog");
        set_case(OC_TMO, OC_TMO, OC_MISS, OC_TMO);
        run_request(32'h0A00_0004, 1'b0, "watchdog_exhaust");
    endtask

    task automatic test_response_vs_watchdog();
        set_case(OC_HIT, OC_HIT, OC_HIT, OC_HIT);
        odly[0] = WC - 1;
        run_request(32'h0A00_0005, 1'b0, "late_hit");
        set_case(OC_MISS, OC_MISS, OC_MISS, OC_MISS);
        for (int i = 0; i <= RM; i++) odly[i] = WC - 1;
        run_request(32'h0A00_0006, 1'b0, "late_miss");
    endtask

    task automatic test_backpressure();
        set_case(OC_MISS, OC_HIT, OC_HIT, OC_HIT);
        qdly = 5; tdly = 5; rdly = 5;
        run_request(32'hDEAD_BEEF, 1'b0, "backpressure");
    endtask

    task automatic test_mid_reset();
        set_case(OC_MISS, OC_HIT, OC_HIT, OC_HIT);
        run_request(32'h0B0B_0B0B, 1'b1, "mid_reset");
        set_case(OC_HIT, OC_HIT, OC_HIT, OC_HIT);
        run_request(32'h0C0C_0C0C, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 20; n++) begin
            set_case(0, 0, 0, 0);
            for (int i = 0; i <= RM; i++) begin
                r = $urandom_range(0, 5);
                oc[i] = (r < 2) ? OC_HIT : (r < 4) ? OC_MISS : OC_TMO;
                r = $urandom_range(0, 4);
                odly[i] = (r == 4) ? WC - 1 : r;
            end
            qdly = $urandom_range(0, 3); tdly = $urandom_range(0, 3); rdly = $urandom_range(0, 3);
            run_request($urandom, 1'b0, $sformatf("random%0d", n));
            repeat ($urandom_range(0, 2)) @(posedge logic_clk);
            #0;
        end
    endtask

    initial begin
        for (int i = 0; i <= RM; i++) begin
            oc[i] = OC_HIT; omac[i] = '0; odly[i] = 0;
        end
        qdly = 0; tdly = 0; rdly = 0;
        test_reset();
        test_hit();
        test_miss_then_hit();
        test_exhaustion();
        test_watchdog();
        test_response_vs_watchdog();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global time limit: got still running want finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/arp_resolve_client.md
# arp_resolve_client

Resolves a destination IPv4 address to a MAC address for user logic in the `logic_clk` domain. It drives the ARP query and ARP trigger ports of the network layer beside the frame datapath. It accepts one IP request at a time and queries the ARP cache. On a cache miss it triggers an ARP request on the wire, backs off, and re-queries until it gets a hit or exhausts its retries. It then returns a MAC or an error flag.

## Interface
- `RETRY_MAX`, 3: number of ARP triggers issued before reporting an error. Total cache queries per request = `RETRY_MAX`+1.
- `WAIT_CYCLES`, 200000: backoff length after each trigger, and the response watchdog length. 1 ms at 200 MHz. Must be ≥ 2.

Ports. Reset is synchronous and active-high. One clock.
- `logic_clk`  in  1  sole clock.
- `logic_rst`  in  1  synchronous active-high reset.
- `req_ip_in`  in  32  IP to resolve.
- `req_valid_in`  in  1  request valid.
- `req_ready_out`  out  1  request accepted when high with valid.
- `rsp_mac_out`  out  48  resolved MAC; 0 on error.
- `rsp_err_out`  out  1  resolution failed.
- `rsp_valid_out`  out  1  result valid.
- `rsp_ready_in`  in  1  result consumed.
- `arp_query_ip_out`  out  32  cache lookup IP.
- `arp_query_valid_out`  out  1  lookup request.
- `arp_query_ready_in`  in  1  lookup accepted.
- `arp_response_mac_in`  in  48  lookup result MAC.
- `arp_response_valid_in`  in  1  lookup result valid.
- `arp_response_err_in`  in  1  lookup miss.
- `arp_response_ready_out`  out  1  lookup result accepted.
- `trig_arp_ip_out`  out  32  IP to broadcast an ARP request for.
- `trig_arp_qvalid_out`  out  1  trigger request.
- `trig_arp_qready_in`  in  1  trigger accepted.

## Operation
- All handshakes are valid/ready.
  - Transfer occurs on a clock edge where both are high.
  - Once asserted, a valid and its payload hold until transfer.
- States: IDLE, QUERY, WAIT_RSP, TRIGGER, BACKOFF, DONE.
- IDLE
  - `req_ready_out`=1.
  - On `req_valid_in`: latch `req_ip_in` into `ip_q`, clear `retry_cnt`, go to QUERY.
- QUERY
  - `arp_query_valid_out`=1 with `arp_query_ip_out`=`ip_q`.
  - On `arp_query_ready_in`: clear `timer`, go to WAIT_RSP.
- WAIT_RSP
  - `arp_response_ready_out`=1. `timer` increments each cycle.
  - On `arp_response_valid_in` with err=0: latch MAC, set err flag 0, go to DONE.
  - On `arp_response_valid_in` with err=1, or `timer`==`WAIT_CYCLES`-1 with no response (watchdog), treat as a miss:
    - if `retry_cnt`==`RETRY_MAX`: set MAC 0, err flag 1, go to DONE;
    - otherwise go to TRIGGER.
  - If a response and the watchdog expiry land in the same cycle, the response wins.
- TRIGGER
  - `trig_arp_qvalid_out`=1 with `trig_arp_ip_out`=`ip_q`.
  - On `trig_arp_qready_in`: `retry_cnt`++, clear `timer`, go to BACKOFF.
- BACKOFF
  - `timer` increments each cycle.
  - At `timer`==`WAIT_CYCLES`-1: go to QUERY.
- DONE
  - `rsp_valid_out`=1 with the latched MAC and err flag.
  - On `rsp_ready_in`: go to IDLE.
- Widths:
  - `retry_cnt` is $clog2(`RETRY_MAX`+1) bits and never wraps.
  - `timer` is $clog2(`WAIT_CYCLES`) bits and never wraps.
  - `ip_q` is 32 bits; the MAC register is 48 bits.
- New requests are blocked (`req_ready_out`=0) in every state except IDLE. There is no request queueing.

## Timing
- Reset values:
  - state IDLE, so `req_ready_out`=1 and all other valid/ready outputs 0;
  - `rsp_mac_out`=0, `rsp_err_out`=0;
  - `arp_query_ip_out`=0, `trig_arp_ip_out`=0;
  - counters 0.
- `logic_rst` in any state returns to IDLE at the next edge. Outstanding valids drop that same edge, and a partial resolution is discarded with no response.
- All handshake outputs are decoded from the state register only. There is no combinational path from any input to any output.
- Latency for a hit with downstream ready tied high:
  - request accepted at edge 0;
  - `arp_query_valid_out` high in cycle 1, accepted at edge 1;
  - response accepted at edge 2;
  - `rsp_valid_out` high in cycle 3.
- Each miss with retries remaining adds 1 TRIGGER cycle, then `WAIT_CYCLES` BACKOFF cycles, then a new QUERY.

## Test plan
- Hit:
  - stimulus: req IP 0xC0A80001; cache returns MAC 0x0011_2233_4455, err=0; ready inputs tied high;
  - required: rsp MAC 0x001122334455, err=0, exactly 3 cycles after req acceptance, with exactly one query and zero triggers.
- Miss then hit:
  - stimulus: `WAIT_CYCLES`=16; first response err=1, second err=0;
  - required: one trigger with IP 0xC0A80001, 16 BACKOFF cycles, second query, then rsp err=0 with the correct MAC.
- Exhaustion:
  - stimulus: `RETRY_MAX`=3; every response err=1;
  - required: 4 queries, 3 triggers, then rsp err=1, MAC 0.
- Watchdog:
  - stimulus: `WAIT_CYCLES`=16; `arp_response_valid_in` never asserted;
  - required: treated as a miss after 16 cycles in WAIT_RSP, then the trigger is issued.
- Backpressure:
  - stimulus: hold `arp_query_ready_in`, `trig_arp_qready_in` and `rsp_ready_in` low for 5 cycles each;
  - required: valids and payloads stay stable for those 5 cycles, and `req_ready_out`=0 throughout.
- Mid-run reset:
  - stimulus: assert `logic_rst` for 1 cycle during BACKOFF;
  - required: all outputs take reset values the next cycle, no rsp is issued, and a new request then resolves normally.
